adder_station: RTL

Reservation station plus integer adder for one ADD/SUB/ADDI/SUBI functional unit.
- Upstream: the reorder buffer's instruction broadcast. It accepts an instruction tagged with a reorder-buffer index.
- Operands come from the register file/status read (value, or the tag of the producing entry). Pending operands are captured by snooping the CDB data bus.
- When the result is ready, it is driven onto its own CDB slot for one cycle, indexed by the reorder-buffer tag.
- One instance per adder FU; busy and flush bits map onto the reorder buffer's `busy`/`reset_out` vectors.

---
 rtl/cpu_pkg.sv | 41 ++++
 rtl/adder_station_if.sv | 35 +++
 rtl/cdb_snoop.sv | 26 ++
 rtl/adder_station.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, READY tag, opcodes, instruction
// layout, adder-station FSM states and the immediate sign-extension helper.
package cpu_pkg;

  localparam int unsigned WORD_SIZE = 32;
  localparam int unsigned RB_SIZE   = 8;
  localparam int unsigned RB_INDEX  = 4;
  localparam int unsigned REG_INDEX = 4;
  localparam int unsigned FU_INDEX  = 4;
  localparam int unsigned OP_W      = 4;
  localparam int unsigned IMM_W     = 16;

  // Tag value meaning "operand value already valid"
  localparam logic [RB_INDEX-1:0] READY = '1;

  localparam logic [OP_W-1:0] INST_ADD  = 4'h1;
  localparam logic [OP_W-1:0] INST_SUB  = 4'h2;
  localparam logic [OP_W-1:0] INST_ADDI = 4'h3;
  localparam logic [OP_W-1:0] INST_SUBI = 4'h4;

  // Instruction layout: op[31:28] rd[27:24] rs[23:20] rt[19:16] imm[15:0]
  typedef struct packed {
    logic [OP_W-1:0]      op;
    logic [REG_INDEX-1:0] rd;
    logic [REG_INDEX-1:0] rs;
    logic [REG_INDEX-1:0] rt;
    logic [IMM_W-1:0]     imm;
  } inst_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_EXEC,
    ST_DONE
  } adder_state_e;

  function automatic logic [WORD_SIZE-1:0] sext_imm(input logic [IMM_W-1:0] imm);
    return {{(WORD_SIZE - IMM_W){imm[IMM_W-1]}}, imm};
  endfunction

endpackage

// File: rtl/adder_station_if.sv
// Adder-station bus bundle: ROB issue broadcast, register-file read,
// CDB snoop inputs, flush, busy and this unit's CDB result slot.
// master = ROB/register-file/CDB side, slave = adder station.
interface adder_station_if;
  import cpu_pkg::*;

  logic [FU_INDEX-1:0]          issue_fu;
  logic [WORD_SIZE-1:0]         issue_inst;
  logic [RB_INDEX-1:0]          issue_rb;
  logic [REG_INDEX-1:0]         numj;
  logic [REG_INDEX-1:0]         numk;
  logic [WORD_SIZE-1:0]         vj;
  logic [WORD_SIZE-1:0]         vk;
  logic [RB_INDEX-1:0]          qj;
  logic [RB_INDEX-1:0]          qk;
  logic [RB_SIZE*WORD_SIZE-1:0] cdb_data;
  logic [RB_SIZE-1:0]           cdb_valid;
  logic                         flush;
  logic                         busy;
  logic [RB_SIZE*WORD_SIZE-1:0] out_data;
  logic [RB_SIZE-1:0]           out_valid;

  modport master (
    output issue_fu, issue_inst, issue_rb, vj, vk, qj, qk,
           cdb_data, cdb_valid, flush,
    input  numj, numk, busy, out_data, out_valid
  );

  modport slave (
    input  issue_fu, issue_inst, issue_rb, vj, vk, qj, qk,
           cdb_data, cdb_valid, flush,
    output numj, numk, busy, out_data, out_valid
  );

endinterface

// File: rtl/cdb_snoop.sv
// Combinational CDB lookup: reports whether the slot named by tag carries a
// valid broadcast this cycle and returns its value.
// Ports: tag (producer tag), cdb_data/cdb_valid (CDB), hit_c, value_c.
module cdb_snoop
  import cpu_pkg::*;
(
  input  logic [RB_INDEX-1:0]          tag,
  input  logic [RB_SIZE*WORD_SIZE-1:0] cdb_data,
  input  logic [RB_SIZE-1:0]           cdb_valid,
  output logic                         hit_c,
  output logic [WORD_SIZE-1:0]         value_c
);

  // Compare per slot so tags beyond RB_SIZE (incl. READY) never match
  always_comb begin
    hit_c   = 1'b0;
    value_c = '0;
    for (int i = 0; i < int'(RB_SIZE); i++) begin
      if (tag != READY && tag == RB_INDEX'(i) && cdb_valid[i]) begin
        hit_c   = 1'b1;
        value_c = cdb_data[i*WORD_SIZE +: WORD_SIZE];
      end
    end
  end

endmodule

// File: rtl/adder_station.sv
// Reservation station + integer adder for one ADD/SUB/ADDI/SUBI unit.
// Ports: clk, reset (sync, active-high), bus (adder_station_if.slave):
//   issue_fu/issue_inst/issue_rb in, numj/numk out (combinational reg addrs),
//   vj/vk/qj/qk in, cdb_data/cdb_valid in, flush in,
//   busy/out_data/out_valid out (registered).
module adder_station
  import cpu_pkg::*;
#(
  parameter int unsigned FU_ID   = 0,
  parameter int unsigned LATENCY = 1
) (
  input logic              clk,
  input logic              reset,
  adder_station_if.slave   bus
);

  localparam int unsigned        CNT_W    = 4;
  localparam logic [CNT_W-1:0]   CNT_LOAD = CNT_W'(LATENCY - 1);

  adder_state_e                 state_q, state_d;
  logic [OP_W-1:0]              op_q, op_d;
  logic [RB_INDEX-1:0]          rb_q, rb_d;
  logic [WORD_SIZE-1:0]         vj_q, vj_d, vk_q, vk_d;
  logic [RB_INDEX-1:0]          qj_q, qj_d, qk_q, qk_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic                         busy_q, busy_d;
  logic [RB_SIZE-1:0]           out_valid_q, out_valid_d;
  logic [RB_SIZE*WORD_SIZE-1:0] out_data_q, out_data_d;

  inst_t                inst_c;
  logic                 issue_hit_c;
  logic                 is_imm_c;
  logic [RB_INDEX-1:0]  tag_j_c, tag_k_c;
  logic                 hit_j_c, hit_k_c;
  logic [WORD_SIZE-1:0] cdb_j_c, cdb_k_c;
  logic [WORD_SIZE-1:0] alu_c;
  logic                 unused_rd;

  // Instruction decode of the broadcast
  assign inst_c      = inst_t'(bus.issue_inst);
  assign issue_hit_c = (bus.issue_fu == FU_INDEX'(FU_ID));
  assign is_imm_c    = (inst_c.op == INST_ADDI) || (inst_c.op == INST_SUBI);
  assign bus.numj    = inst_c.rs;
  assign bus.numk    = inst_c.rt;
  assign unused_rd   = ^inst_c.rd;

  // At issue snoop the incoming tags, afterwards the latched ones
  assign tag_j_c = (state_q == ST_IDLE) ? bus.qj : qj_q;
  assign tag_k_c = (state_q == ST_IDLE) ? bus.qk : qk_q;

  cdb_snoop u_snoop_j (
    .tag       (tag_j_c),
    .cdb_data  (bus.cdb_data),
    .cdb_valid (bus.cdb_valid),
    .hit_c     (hit_j_c),
    .value_c   (cdb_j_c)
  );

  cdb_snoop u_snoop_k (
    .tag       (tag_k_c),
    .cdb_data  (bus.cdb_data),
    .cdb_valid (bus.cdb_valid),
    .hit_c     (hit_k_c),
    .value_c   (cdb_k_c)
  );

  // Adder; immediate forms already hold sext(imm) in vk
  always_comb begin
    alu_c = '0;
    case (op_q)
      INST_ADD, INST_ADDI: alu_c = vj_q + vk_q;
      INST_SUB, INST_SUBI: alu_c = vj_q - vk_q;
      default:             alu_c = '0;
    endcase
  end

  // Next-state, operand capture and result slot
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    rb_d        = rb_q;
    vj_d        = vj_q;
    vk_d        = vk_q;
    qj_d        = qj_q;
    qk_d        = qk_q;
    cnt_d       = cnt_q;
    out_valid_d = '0;
    out_data_d  = '0;

    case (state_q)
      ST_IDLE: begin
        if (issue_hit_c) begin
          op_d = inst_c.op;
          rb_d = bus.issue_rb;
          if (hit_j_c) begin
            vj_d = cdb_j_c;
            qj_d = READY;
          end else begin
            vj_d = bus.vj;
            qj_d = bus.qj;
          end
          if (is_imm_c) begin
            vk_d = sext_imm(inst_c.imm);
            qk_d = READY;
          end else if (hit_k_c) begin
            vk_d = cdb_k_c;
            qk_d = READY;
          end else begin
            vk_d = bus.vk;
            qk_d = bus.qk;
          end
          if (qj_d == READY && qk_d == READY) begin
            state_d = ST_EXEC;
            cnt_d   = CNT_LOAD;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (hit_j_c) begin
          vj_d = cdb_j_c;
          qj_d = READY;
        end
        if (hit_k_c) begin
          vk_d = cdb_k_c;
          qk_d = READY;
        end
        if (qj_d == READY && qk_d == READY) begin
          state_d = ST_EXEC;
          cnt_d   = CNT_LOAD;
        end
      end
      ST_EXEC: begin
        if (cnt_q == '0) begin
          state_d = ST_DONE;
          for (int i = 0; i < int'(RB_SIZE); i++) begin
            if (rb_q == RB_INDEX'(i)) begin
              out_valid_d[i]                        = 1'b1;
              out_data_d[i*WORD_SIZE +: WORD_SIZE] = alu_c;
            end
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Flush kills issue, capture and any pending result
    if (bus.flush) begin
      state_d     = ST_IDLE;
      out_valid_d = '0;
      out_data_d  = '0;
    end

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      op_q        <= '0;
      rb_q        <= '0;
      vj_q        <= '0;
      vk_q        <= '0;
      qj_q        <= READY;
      qk_q        <= READY;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      out_valid_q <= '0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      rb_q        <= rb_d;
      vj_q        <= vj_d;
      vk_q        <= vk_d;
      qj_q        <= qj_d;
      qk_q        <= qk_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;

endmodule
